// File: rtl/mem_arb_pkg.sv
// Shared definitions for the RAM port arbiter: FSM states, owner IDs and
// the values the RAM strobes take whenever no access is in flight.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  localparam logic RAM_CS_IDLE = 1'b0;
  localparam logic RAM_WE_IDLE = 1'b0;
  localparam logic RAM_OE_IDLE = 1'b0;

endpackage

// File: rtl/mem_arb_sel.sv
// Winner selection between the fetch and data requesters.
// MEM_ARB_RR_EN defined: round-robin, the non-last owner wins a tie.
// MEM_ARB_RR_EN undefined: data wins ties unless fetch has hit the starvation limit.
module mem_arb_sel
  import mem_arb_pkg::*;
(
  input  logic if_req,
  input  logic d_req,
`ifdef MEM_ARB_RR_EN
  input  logic last_own,
`else
  input  logic starve_lim,
`endif
  output logic gnt_if,
  output logic gnt_d
);

  // One-hot grant; a lone requester always wins, ties follow the policy.
  always_comb begin
    gnt_if = 1'b0;
    gnt_d  = 1'b0;
    if (if_req && d_req) begin
`ifdef MEM_ARB_RR_EN
      if (last_own == OWN_D) gnt_if = 1'b1;
      else                   gnt_d  = 1'b1;
`else
      if (starve_lim) gnt_if = 1'b1;
      else            gnt_d  = 1'b1;
`endif
    end else begin
      gnt_if = if_req;
      gnt_d  = d_req;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the single RAM port (instruction fetch vs data
// load/store). One access at a time: IDLE -> ACCESS (RAM_LAT cycles) -> DONE.
// Arbitration policy selected by MEM_ARB_RR_EN (see mem_arb_sel).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int RAM_LAT  = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              ram_cs,
  output logic              ram_we,
  output logic              ram_oe,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int CNT_W = $clog2(RAM_LAT + 1);

  state_t            state;
  owner_t            owner;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CNT_W-1:0]  cnt;
  logic              sel_if;
  logic              sel_d;
  logic              idle;
  logic              in_acc;

  assign idle   = (state == ST_IDLE);
  assign in_acc = (state == ST_ACCESS);

  // Grants are combinational in IDLE; masked during reset so they read 0.
  assign if_gnt = idle && !rst && sel_if;
  assign d_gnt  = idle && !rst && sel_d;

  // RAM strobes come straight from state so reset clears them at once.
  assign ram_cs    = in_acc ? 1'b1   : RAM_CS_IDLE;
  assign ram_we    = in_acc ? we_q   : RAM_WE_IDLE;
  assign ram_oe    = in_acc ? !we_q  : RAM_OE_IDLE;
  assign ram_addr  = in_acc ? addr_q  : '0;
  assign ram_wdata = in_acc ? wdata_q : '0;

`ifdef MEM_ARB_RR_EN
  mem_arb_sel u_sel (
    .if_req   (if_req),
    .d_req    (d_req),
    .last_own (owner),
    .gnt_if   (sel_if),
    .gnt_d    (sel_d)
  );
`else
  localparam int SW = $clog2(MAX_WAIT + 1);

  logic [SW-1:0] starve;
  logic          starve_lim;

  assign starve_lim = (starve == SW'(MAX_WAIT));

  // Count data grants that overtake a waiting fetch; saturate at MAX_WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve <= '0;
    end else if (if_gnt) begin
      starve <= '0;
    end else if (d_gnt && if_req) begin
      if (!starve_lim) starve <= starve + SW'(1);
    end else if (idle && !if_req) begin
      starve <= '0;
    end
  end

  mem_arb_sel u_sel (
    .if_req     (if_req),
    .d_req      (d_req),
    .starve_lim (starve_lim),
    .gnt_if     (sel_if),
    .gnt_d      (sel_d)
  );
`endif

  // Access FSM: latch the winner's request, hold the RAM for RAM_LAT
  // cycles, capture read data on the last one and pulse rvalid in DONE.
  // The owner register doubles as the last-owner record for round-robin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      owner     <= OWN_IF;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt       <= '0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (if_gnt) begin
            owner   <= OWN_IF;
            we_q    <= 1'b0;
            addr_q  <= if_addr;
            wdata_q <= '0;
            cnt     <= CNT_W'(RAM_LAT);
            state   <= ST_ACCESS;
          end else if (d_gnt) begin
            owner   <= OWN_D;
            we_q    <= d_we;
            addr_q  <= d_addr;
            wdata_q <= d_wdata;
            cnt     <= CNT_W'(RAM_LAT);
            state   <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (cnt == CNT_W'(1)) begin
            state <= ST_DONE;
            if (owner == OWN_IF) begin
              if_rvalid <= 1'b1;
              if_rdata  <= ram_rdata;
            end else begin
              d_rvalid <= 1'b1;
              d_rdata  <= we_q ? '0 : ram_rdata;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_DONE: begin
          if_rvalid <= 1'b0;
          d_rvalid  <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter (RAM_LAT=3, MAX_WAIT=4). A transaction-
// level reference model predicts grants, RAM strobes and rvalid/rdata per cycle.
// Build with MEM_ARB_RR_EN defined to check the round-robin variant.
module tb_mem_arbiter;

  localparam int LAT  = 3;
  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid;
  logic [31:0] if_rdata, d_rdata;
  logic        ram_cs, ram_we, ram_oe;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;

  mem_arbiter #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .RAM_LAT  (LAT),
    .MAX_WAIT (MAXW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .ram_cs    (ram_cs),
    .ram_we    (ram_we),
    .ram_oe    (ram_oe),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: 64 words indexed by address[5:0].
  logic [31:0] ram_mem [64];
  assign ram_rdata = ram_cs ? ram_mem[ram_addr[5:0]] : 32'h0;
  always @(posedge clk) if (ram_cs && ram_we) ram_mem[ram_addr[5:0]] <= ram_wdata;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state (transaction level).
  logic [31:0] ref_mem [64];
  int          m_left;    // cycles left in the current transaction, 0 = free
  bit          m_own_d;
  bit          m_we;
  bit          m_last_d;
  int          m_starve;
  logic [31:0] m_addr, m_wdata;
  int          gnt_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_left   = 0;
    m_own_d  = 1'b0;
    m_we     = 1'b0;
    m_last_d = 1'b0;
    m_starve = 0;
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                       input logic dw, input logic [31:0] da, input logic [31:0] dd);
    if_req  = ir;
    if_addr = ia;
    d_req   = dr;
    d_we    = dw;
    d_addr  = da;
    d_wdata = dd;
  endtask

  // Sample at the falling edge, compare with the model, then advance it.
  task automatic step();
    bit w_if, w_d;
    @(negedge clk);
    if (m_left == 0) begin
      w_if = 1'b0;
      w_d  = 1'b0;
      if (if_req && d_req) begin
`ifdef MEM_ARB_RR_EN
        if (m_last_d) w_if = 1'b1; else w_d = 1'b1;
`else
        if (m_starve >= MAXW) w_if = 1'b1; else w_d = 1'b1;
`endif
      end else begin
        w_if = if_req;
        w_d  = d_req;
      end
      chk("idle_if_gnt", 32'(if_gnt), 32'(w_if));
      chk("idle_d_gnt", 32'(d_gnt), 32'(w_d));
      chk("idle_ram_cs", 32'(ram_cs), 32'd0);
      chk("idle_ram_strobes", 32'({ram_we, ram_oe}), 32'd0);
      chk("idle_ram_addr", ram_addr, 32'd0);
      chk("idle_ram_wdata", ram_wdata, 32'd0);
      chk("idle_rvalid", 32'({if_rvalid, d_rvalid}), 32'd0);
      if (if_gnt) gnt_log.push_back(0);
      if (d_gnt)  gnt_log.push_back(1);
      if (!if_req) m_starve = 0;
      if (w_if) m_starve = 0;
      else if (w_d && if_req && m_starve < MAXW) m_starve++;
      if (w_if || w_d) begin
        m_own_d  = w_d;
        m_last_d = w_d;
        m_we     = w_d && d_we;
        m_addr   = w_d ? d_addr : if_addr;
        m_wdata  = d_wdata;
        if (m_we) ref_mem[m_addr[5:0]] = m_wdata;
        m_left   = LAT + 1;
      end
    end else if (m_left > 1) begin
      chk("acc_gnt", 32'({if_gnt, d_gnt}), 32'd0);
      chk("acc_ram_cs", 32'(ram_cs), 32'd1);
      chk("acc_ram_we", 32'(ram_we), 32'(m_we));
      chk("acc_ram_oe", 32'(ram_oe), 32'(!m_we));
      chk("acc_ram_addr", ram_addr, m_addr);
      if (m_we) chk("acc_ram_wdata", ram_wdata, m_wdata);
      chk("acc_rvalid", 32'({if_rvalid, d_rvalid}), 32'd0);
      m_left--;
    end else begin
      chk("done_gnt", 32'({if_gnt, d_gnt}), 32'd0);
      chk("done_ram_cs", 32'(ram_cs), 32'd0);
      chk("done_if_rvalid", 32'(if_rvalid), 32'(!m_own_d));
      chk("done_d_rvalid", 32'(d_rvalid), 32'(m_own_d));
      if (m_own_d) chk("done_d_rdata", d_rdata, m_we ? 32'd0 : ref_mem[m_addr[5:0]]);
      else         chk("done_if_rdata", if_rdata, ref_mem[m_addr[5:0]]);
      m_left = 0;
    end
  endtask

  task automatic cycle(input logic ir, input logic [31:0] ia, input logic dr,
                       input logic dw, input logic [31:0] da, input logic [31:0] dd);
    @(posedge clk);
    #1;
    drive(ir, ia, dr, dw, da, dd);
    step();
  endtask

  task automatic drain();
    for (int i = 0; i < LAT + 3; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      ram_mem[i] = 32'hA5000000 + 32'(i) * 32'h00010203;
      ref_mem[i] = ram_mem[i];
    end
    ram_mem[16] = 32'h00500093;
    ref_mem[16] = 32'h00500093;
    model_reset();

    // Reset: requests present but nothing may be granted or driven.
    rst = 1'b1;
    drive(1'b1, 32'h4, 1'b1, 1'b0, 32'h8, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", 32'({if_gnt, d_gnt}), 32'd0);
    chk("rst_rvalid", 32'({if_rvalid, d_rvalid}), 32'd0);
    chk("rst_ram", 32'({ram_cs, ram_we, ram_oe}), 32'd0);
    chk("rst_ram_addr", ram_addr, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();

    // Both requests held: grant order from reset.
    gnt_log.delete();
    for (int i = 0; i < 10 * (LAT + 2); i++)
      cycle(1'b1, 32'h20, 1'b1, 1'b0, 32'h24, 32'h0);
    drain();
    chk("order_len", 32'(gnt_log.size()), 32'd10);
    for (int i = 0; i < 10; i++) begin
`ifdef MEM_ARB_RR_EN
      chk("order_rr", 32'(gnt_log[i]), (i % 2 == 0) ? 32'd1 : 32'd0);
`else
      chk("order_fixed", 32'(gnt_log[i]), (i % 5 == 4) ? 32'd0 : 32'd1);
`endif
    end

    // Single fetch read.
    cycle(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
    drain();
    chk("fetch_rdata_hold", if_rdata, 32'h00500093);

    // Data write, then read it back.
    cycle(1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF);
    drain();
    chk("write_rdata_zero", d_rdata, 32'd0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0);
    drain();
    chk("readback", d_rdata, 32'hDEADBEEF);

    // Reset in the second ACCESS cycle of a write, with a read request held.
    cycle(1'b0, 32'h0, 1'b1, 1'b1, 32'h08, 32'h11112222);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0C, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_ram_cs", 32'(ram_cs), 32'd0);
    chk("midrst_ram_we", 32'(ram_we), 32'd0);
    chk("midrst_rvalid", 32'({if_rvalid, d_rvalid}), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("inrst_gnt", 32'({if_gnt, d_gnt}), 32'd0);
    chk("inrst_rvalid", 32'({if_rvalid, d_rvalid}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    chk("regrant_log", 32'(gnt_log[gnt_log.size() - 1]), 32'd1);
    drain();

    // Randomised traffic.
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), $urandom, $urandom);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
